id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage directly downstream of the instruction fetch stage. Consumes the fetched 8-bit instruction byte and its PC every cycle.
- Assembles two-byte instructions (LDI, JMP, JZ) with a small FSM and emits registered decoded fields to execute.
- Drives the jump request (JFlag/NewJadd) back to fetch and squashes wrong-path bytes fetched while a jump is redirecting.

Parameters:
- PC_W, 8, width of PC, instr_pc and NewJadd.
- FLUSH_CYCLES, 1, number of wrong-path bytes discarded after JFlag asserts (>=1).

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low
- Code  in  8  instruction byte from fetch, valid each cycle
- PC  in  PC_W  address of Code
- zero_flag  in  1  zero flag from execute, sampled for JZ
- dec_valid  out  1  decoded instruction valid this cycle
- alu_op  out  3  opcode field of decoded instruction
- rd  out  2  destination register
- rs  out  2  source register
- imm  out  8  immediate (LDI only, else 0)
- instr_pc  out  PC_W  PC of first byte of decoded instruction
- JFlag  out  1  jump request to fetch, one-cycle pulse
- NewJadd  out  PC_W  jump target, valid while JFlag=1

Behaviour:
- Encoding: Code[7:5]=op, [4:3]=rd, [2:1]=rs, [0] ignored.
  - 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR: single byte.
  - 101 LDI rd,#imm; 110 JMP #tgt; 111 JZ #tgt: two bytes, second byte is imm/target.
- Reset (async, reset=0): state=DECODE, flush counter=0. All outputs 0.
- All outputs are registered and update on the rising clk edge.
- FSM states DECODE, OPERAND, FLUSH.
- DECODE:
  - Single-byte op: next cycle dec_valid=1 with alu_op/rd/rs, imm=0, instr_pc=PC.
    - NOP also produces dec_valid=1 with alu_op=000.
  - Op 101/110/111: latch op, rd, rs and PC; go to OPERAND; dec_valid=0 next cycle.
- OPERAND (Code is the second byte):
  - LDI: next cycle dec_valid=1, alu_op=101, imm=Code, instr_pc=latched PC; go to DECODE.
  - JMP: next cycle JFlag=1, NewJadd=Code (zero-extended/truncated to PC_W), dec_valid=0; go to FLUSH, counter=FLUSH_CYCLES.
  - JZ with zero_flag=1 at this edge: identical to JMP.
  - JZ with zero_flag=0: no jump, dec_valid=0; go to DECODE.
- FLUSH:
  - Code is wrong-path and is ignored; dec_valid=0.
  - Counter decrements each cycle; at 1 go to DECODE.
  - JFlag is high only during the first FLUSH cycle, then 0.
  - NewJadd holds its value until the next jump.
- Jump latency: fetch loads NewJadd at the edge ending the JFlag cycle. With FLUSH_CYCLES=1 the first byte decoded after a JMP is at the target, 3 cycles after the JMP opcode is presented.
- dec_valid and JFlag are never high in the same cycle.
- Wrap-around: PC/target arithmetic is not performed here. Target 0xFF is legal.
- Reset mid-operation (in OPERAND or FLUSH): returns immediately to DECODE. A pending JFlag drops asynchronously and the partially assembled instruction is discarded.
- A two-byte opcode presented as the second byte is consumed as data, never decoded.

Test Plan:
- Reset then stream 0x2A (ADD rd=1,rs=1), 0x4C (SUB rd=1,rs=2) at PC 0,1 -> dec_valid=1 for two cycles: alu_op=001,rd=1,rs=1,instr_pc=0; then alu_op=010,rd=1,rs=2,instr_pc=1.
- LDI: 0xB0 then 0x5A at PC 4,5 -> one bubble, then dec_valid=1, alu_op=101, rd=2, imm=0x5A, instr_pc=4.
- JMP: 0xC0,0x20 at PC 6,7, wrong-path 0x2A at PC 8 -> JFlag=1 with NewJadd=0x20 for exactly one cycle; byte at PC 8 not decoded; next dec_valid reports instr_pc=0x20.
- JZ taken/not taken: 0xE0,0x10 with zero_flag=1 -> JFlag=1, NewJadd=0x10. Same with zero_flag=0 -> JFlag stays 0, following byte decoded normally.
- Reset asserted during the FLUSH cycle (JFlag=1) -> JFlag and all outputs 0 immediately; after release, first byte decoded as a fresh instruction.
- FLUSH_CYCLES=2 build: JMP -> two wrong-path bytes squashed, JFlag still a single-cycle pulse.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage: assembles one/two-byte instructions and requests jumps.
// Wrong-path bytes behind a taken jump are squashed for FLUSH_CYCLES.
module id_stage #(
  parameter int PC_W         = 8,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      Code,
  input  logic [PC_W-1:0] PC,
  input  logic            zero_flag,
  output logic            dec_valid,
  output logic [2:0]      alu_op,
  output logic [1:0]      rd,
  output logic [1:0]      rs,
  output logic [7:0]      imm,
  output logic [PC_W-1:0] instr_pc,
  output logic            JFlag,
  output logic [PC_W-1:0] NewJadd
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_JZ  = 3'b111;

  typedef enum logic [1:0] {
    DECODE,
    OPERAND,
    FLUSH
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      op_q, op_n;
  logic [1:0]      rd_q, rd_qn;
  logic [1:0]      rs_q, rs_qn;
  logic [PC_W-1:0] pc_q, pc_qn;

  logic            valid_n;
  logic [2:0]      alu_op_n;
  logic [1:0]      rd_n;
  logic [1:0]      rs_n;
  logic [7:0]      imm_n;
  logic [PC_W-1:0] ipc_n;
  logic            jflag_n;
  logic [PC_W-1:0] jadd_n;

  logic            two_byte;
  logic            take;

  assign two_byte = Code[7] & (Code[6] | Code[5]);
  assign take     = (op_q == OP_JMP) |
                    ((op_q == OP_JZ) & zero_flag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DECODE;
      cnt       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      pc_q      <= '0;
      dec_valid <= 1'b0;
      alu_op    <= '0;
      rd        <= '0;
      rs        <= '0;
      imm       <= '0;
      instr_pc  <= '0;
      JFlag     <= 1'b0;
      NewJadd   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      op_q      <= op_n;
      rd_q      <= rd_qn;
      rs_q      <= rs_qn;
      pc_q      <= pc_qn;
      dec_valid <= valid_n;
      alu_op    <= alu_op_n;
      rd        <= rd_n;
      rs        <= rs_n;
      imm       <= imm_n;
      instr_pc  <= ipc_n;
      JFlag     <= jflag_n;
      NewJadd   <= jadd_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    op_n     = op_q;
    rd_qn    = rd_q;
    rs_qn    = rs_q;
    pc_qn    = pc_q;
    valid_n  = 1'b0;
    alu_op_n = alu_op;
    rd_n     = rd;
    rs_n     = rs;
    imm_n    = imm;
    ipc_n    = instr_pc;
    jflag_n  = 1'b0;
    jadd_n   = NewJadd;

    unique case (state)
      DECODE: begin
        unique case (1'b1)
          two_byte: begin
            op_n    = Code[7:5];
            rd_qn   = Code[4:3];
            rs_qn   = Code[2:1];
            pc_qn   = PC;
            state_n = OPERAND;
          end
          default: begin
            valid_n  = 1'b1;
            alu_op_n = Code[7:5];
            rd_n     = Code[4:3];
            rs_n     = Code[2:1];
            imm_n    = '0;
            ipc_n    = PC;
          end
        endcase
      end

      OPERAND: begin
        unique case (1'b1)
          (op_q == OP_LDI): begin
            valid_n  = 1'b1;
            alu_op_n = OP_LDI;
            rd_n     = rd_q;
            rs_n     = rs_q;
            imm_n    = Code;
            ipc_n    = pc_q;
            state_n  = DECODE;
          end
          take: begin
            jflag_n = 1'b1;
            jadd_n  = PC_W'(Code);
            cnt_n   = CW'(FLUSH_CYCLES);
            state_n = FLUSH;
          end
          default: begin
            state_n = DECODE;
          end
        endcase
      end

      FLUSH: begin
        // Code here is wrong-path; only the squash count advances.
        if (cnt <= CW'(1)) begin
          cnt_n   = '0;
          state_n = DECODE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end

      default: begin
        state_n = DECODE;
      end
    endcase
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: FLUSH_CYCLES=1 and =2 instances against
// a byte-stream reference model; directed steps then random.
module tb_id_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Code;
  logic [7:0] PC;
  logic       zero_flag;

  logic       dv [2];
  logic [2:0] ao [2];
  logic [1:0] rdo [2];
  logic [1:0] rso [2];
  logic [7:0] imo [2];
  logic [7:0] ipo [2];
  logic       jfo [2];
  logic [7:0] jao [2];

  always #5 clk = ~clk;

  id_stage #(.PC_W(8), .FLUSH_CYCLES(1)) u_f1 (
    .clk(clk), .reset(reset), .Code(Code), .PC(PC),
    .zero_flag(zero_flag),
    .dec_valid(dv[0]), .alu_op(ao[0]), .rd(rdo[0]),
    .rs(rso[0]), .imm(imo[0]), .instr_pc(ipo[0]),
    .JFlag(jfo[0]), .NewJadd(jao[0])
  );

  id_stage #(.PC_W(8), .FLUSH_CYCLES(2)) u_f2 (
    .clk(clk), .reset(reset), .Code(Code), .PC(PC),
    .zero_flag(zero_flag),
    .dec_valid(dv[1]), .alu_op(ao[1]), .rd(rdo[1]),
    .rs(rso[1]), .imm(imo[1]), .instr_pc(ipo[1]),
    .JFlag(jfo[1]), .NewJadd(jao[1])
  );

  int passed = 0;
  int total  = 0;

  int         fl [2] = '{1, 2};
  int         skip [2];
  bit         have [2];
  logic [7:0] first [2];
  logic [7:0] fpc [2];

  logic       e_v [2];
  logic [2:0] e_op [2];
  logic [1:0] e_rd [2];
  logic [1:0] e_rs [2];
  logic [7:0] e_imm [2];
  logic [7:0] e_pc [2];
  logic       e_jf [2];
  logic [7:0] e_ja [2];

  logic [7:0] pc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      skip[k] = 0;  have[k] = 0;
      first[k] = 0; fpc[k] = 0;
      e_v[k] = 0;   e_op[k] = 0; e_rd[k] = 0; e_rs[k] = 0;
      e_imm[k] = 0; e_pc[k] = 0; e_jf[k] = 0; e_ja[k] = 0;
    end
  endtask

  // One byte consumed by the decoder: what it must show next cycle.
  task automatic model_step(int k, logic [7:0] c, logic [7:0] p, logic z);
    int op;
    e_v[k]  = 0;
    e_jf[k] = 0;
    if (skip[k] > 0) begin
      skip[k]--;
    end else if (have[k]) begin
      have[k] = 0;
      op = int'(first[k][7:5]);
      if (op == 5) begin
        e_v[k] = 1; e_op[k] = 3'd5;
        e_rd[k] = first[k][4:3]; e_rs[k] = first[k][2:1];
        e_imm[k] = c; e_pc[k] = fpc[k];
      end else if (op == 6 || z) begin
        e_jf[k] = 1; e_ja[k] = c; skip[k] = fl[k];
      end
    end else begin
      op = int'(c[7:5]);
      if (op >= 5) begin
        have[k] = 1; first[k] = c; fpc[k] = p;
      end else begin
        e_v[k] = 1; e_op[k] = c[7:5];
        e_rd[k] = c[4:3]; e_rs[k] = c[2:1];
        e_imm[k] = 0; e_pc[k] = p;
      end
    end
  endtask

  task automatic compare(int k);
    string s;
    s = $sformatf("u%0d@%0h", k, PC);
    chk({s, " dec_valid"}, 32'(dv[k]), 32'(e_v[k]));
    chk({s, " JFlag"}, 32'(jfo[k]), 32'(e_jf[k]));
    chk({s, " NewJadd"}, 32'(jao[k]), 32'(e_ja[k]));
    if (e_v[k]) begin
      chk({s, " alu_op"}, 32'(ao[k]), 32'(e_op[k]));
      chk({s, " rd"}, 32'(rdo[k]), 32'(e_rd[k]));
      chk({s, " rs"}, 32'(rso[k]), 32'(e_rs[k]));
      chk({s, " imm"}, 32'(imo[k]), 32'(e_imm[k]));
      chk({s, " instr_pc"}, 32'(ipo[k]), 32'(e_pc[k]));
    end
  endtask

  task automatic check_zero(string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s u%0d dv", tag, k), 32'(dv[k]), 0);
      chk($sformatf("%s u%0d op", tag, k), 32'(ao[k]), 0);
      chk($sformatf("%s u%0d rd", tag, k), 32'(rdo[k]), 0);
      chk($sformatf("%s u%0d rs", tag, k), 32'(rso[k]), 0);
      chk($sformatf("%s u%0d imm", tag, k), 32'(imo[k]), 0);
      chk($sformatf("%s u%0d ipc", tag, k), 32'(ipo[k]), 0);
      chk($sformatf("%s u%0d jf", tag, k), 32'(jfo[k]), 0);
      chk($sformatf("%s u%0d ja", tag, k), 32'(jao[k]), 0);
    end
  endtask

  // Present one byte; fetch follows the FLUSH_CYCLES=1 instance.
  task automatic cyc(logic [7:0] c, logic z);
    logic       jf_now;
    logic [7:0] ja_now;
    jf_now    = e_jf[0];
    ja_now    = e_ja[0];
    Code      = c;
    PC        = pc;
    zero_flag = z;
    @(posedge clk);
    model_step(0, c, pc, z);
    model_step(1, c, pc, z);
    #1;
    compare(0);
    compare(1);
    pc = jf_now ? ja_now : pc + 8'd1;
  endtask

  initial begin
    reset = 1'b0; Code = '0; PC = '0; zero_flag = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    reset = 1'b1;

    pc = 8'd0;
    cyc(8'h2A, 0);
    chk("add ipc", 32'(ipo[0]), 32'h0);
    cyc(8'h4C, 0);
    chk("sub op", 32'(ao[0]), 32'h2);

    pc = 8'd4;
    cyc(8'hB0, 0);
    cyc(8'h5A, 0);
    chk("ldi imm", 32'(imo[0]), 32'h5A);
    chk("ldi ipc", 32'(ipo[0]), 32'h4);

    pc = 8'd6;
    cyc(8'hC0, 0);
    cyc(8'h20, 0);
    chk("jmp jf", 32'(jfo[1]), 32'h1);
    cyc(8'h2A, 0);
    chk("jmp pc after", 32'(pc), 32'h20);
    cyc(8'h2A, 0);
    chk("jmp land", 32'(ipo[0]), 32'h20);
    cyc(8'h4C, 0);

    cyc(8'hE0, 1);
    cyc(8'h10, 1);
    cyc(8'h6E, 0);
    cyc(8'h2A, 0);
    cyc(8'h00, 0);
    cyc(8'hE0, 0);
    cyc(8'h10, 0);
    cyc(8'h8A, 0);

    cyc(8'hB8, 0);
    cyc(8'hE0, 0);
    cyc(8'h2A, 0);

    cyc(8'hC0, 0);
    cyc(8'hFF, 0);
    reset = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    #2;
    reset = 1'b1;
    pc = 8'd3;
    cyc(8'h6A, 0);
    cyc(8'hE6, 1);
    cyc(8'hFF, 1);
    cyc(8'h2A, 0);
    cyc(8'h2A, 0);
    cyc(8'h4C, 0);

    for (int i = 0; i < 300; i++) begin
      cyc(8'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
